// File: rtl/dmem_access_ctrl.sv
// Byte-beat sequencer/arbiter for a single-port byte-wide data memory shared by core and debug.
// Define DMEM_BOUNDS_CHECK_EN to suppress and flag accesses that run past MEM_BYTES.
module dmem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [1:0]        core_size,
  input  logic              core_unsigned,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_done,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic              dbg_unsigned,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StBeat, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;  // 1 = debug requester
  logic              we_q, we_d, uns_q, uns_d, oob_q, oob_d;
  logic              prio_dbg_q, prio_dbg_d;
  logic              cap_v_q, cap_v_d;
  logic [1:0]        size_q, size_d, k_q, k_d, last_k_q, last_k_d, cap_idx_q, cap_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, buf_q, buf_d, result;
  logic [31:0]       core_rdata_q, core_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic              core_done_q, core_done_d, dbg_done_q, dbg_done_d, err_q, err_d;

  logic              grant_dbg, any_req, sel_we, sel_uns, sel_oob;
  logic [1:0]        sel_size, sel_last_k;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  // On a tie the requester that was not served last wins; after reset the core wins.
  always_comb begin
    any_req   = core_req | dbg_req;
    grant_dbg = dbg_req & (~core_req | prio_dbg_q);
    sel_we    = grant_dbg ? dbg_we       : core_we;
    sel_uns   = grant_dbg ? dbg_unsigned : core_unsigned;
    sel_size  = grant_dbg ? dbg_size     : core_size;
    sel_addr  = grant_dbg ? dbg_addr     : core_addr;
    sel_wdata = grant_dbg ? dbg_wdata    : core_wdata;
    case (sel_size)
      2'b00:   sel_last_k = 2'd0;
      2'b01:   sel_last_k = 2'd1;
      default: sel_last_k = 2'd3;
    endcase
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  logic [ADDR_W:0] sel_end;
  assign sel_end = {1'b0, sel_addr} + {{(ADDR_W-1){1'b0}}, sel_last_k};
  assign sel_oob = sel_end >= (ADDR_W+1)'(MEM_BYTES);
`else
  assign sel_oob = 1'b0;
`endif

  // Read byte of beat k arrives one cycle later; this capture overlaps the next beat.
  always_comb begin
    buf_d = buf_q;
    if (cap_v_q) buf_d[8*cap_idx_q +: 8] = mem_rdata;
  end

  always_comb begin
    case (size_q)
      2'b00:   result = {{24{~uns_q & buf_d[7]}}, buf_d[7:0]};
      2'b01:   result = {{16{~uns_q & buf_d[15]}}, buf_d[15:0]};
      default: result = buf_d;
    endcase
    if (we_q || oob_q) result = '0;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    uns_d        = uns_q;
    oob_d        = oob_q;
    size_d       = size_q;
    last_k_d     = last_k_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    k_d          = k_q;
    prio_dbg_d   = prio_dbg_q;
    cap_v_d      = 1'b0;
    cap_idx_d    = cap_idx_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    core_done_d  = 1'b0;
    dbg_done_d   = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d    = grant_dbg;
          we_d       = sel_we;
          uns_d      = sel_uns;
          oob_d      = sel_oob;
          size_d     = sel_size;
          last_k_d   = sel_last_k;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          k_d        = 2'd0;
          prio_dbg_d = ~grant_dbg;
          if (grant_dbg) dbg_rdata_d = '0;
          else           core_rdata_d = '0;
          state_d    = StBeat;
        end
      end
      StBeat: begin
        cap_v_d   = ~we_q & ~oob_q;
        cap_idx_d = k_q;
        if (k_q == last_k_q) begin
          k_d     = 2'd0;
          state_d = StWait;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      StWait: begin
        state_d = StResp;
        err_d   = oob_q;
        if (owner_q) begin
          dbg_done_d  = 1'b1;
          dbg_rdata_d = result;
        end else begin
          core_done_d  = 1'b1;
          core_rdata_d = result;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == StBeat) begin
      mem_en    = ~oob_q;
      mem_we    = we_q & ~oob_q;
      mem_addr  = (addr_q + ADDR_W'(k_q)) & ADDR_W'(MEM_BYTES - 1);
      mem_wdata = wdata_q[8*k_q +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      oob_q        <= 1'b0;
      size_q       <= 2'd0;
      last_k_q     <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      k_q          <= 2'd0;
      prio_dbg_q   <= 1'b0;
      cap_v_q      <= 1'b0;
      cap_idx_q    <= 2'd0;
      buf_q        <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
      core_done_q  <= 1'b0;
      dbg_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      oob_q        <= oob_d;
      size_q       <= size_d;
      last_k_q     <= last_k_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      k_q          <= k_d;
      prio_dbg_q   <= prio_dbg_d;
      cap_v_q      <= cap_v_d;
      cap_idx_q    <= cap_idx_d;
      buf_q        <= buf_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      core_done_q  <= core_done_d;
      dbg_done_q   <= dbg_done_d;
      err_q        <= err_d;
    end
  end

  assign core_rdata = core_rdata_q;
  assign core_done  = core_done_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_done   = dbg_done_q;
  assign err        = err_q;
  assign core_stall = core_req & ~core_done_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequencer and arbiter for a byte-wide, single-port data memory (MEM_BYTES bytes).
- Shares the port between the core load/store path and a debug/loader requester.
- Breaks each byte, half or word access into little-endian byte beats, then returns sign- or zero-extended read data.
- Stalls the core while its access is pending.

Parameters:
MEM_BYTES, 128, memory size in bytes; must be a power of two
ADDR_W, 32, requester address width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
core_req  in  1  core access request; held until core_done
core_we  in  1  1=store, 0=load
core_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
core_unsigned  in  1  zero-extend load (lbu/lhu)
core_addr  in  ADDR_W  byte address; misaligned allowed
core_wdata  in  32  store data
core_rdata  out  32  load result, valid when core_done
core_done  out  1  one-cycle completion pulse
core_stall  out  1  freeze core PC/writeback
dbg_req, dbg_we, dbg_size, dbg_unsigned, dbg_addr, dbg_wdata, dbg_rdata, dbg_done  same widths and meaning as the core_* ports, for the debug requester
mem_en  out  1  memory beat strobe
mem_we  out  1  byte write strobe
mem_addr  out  ADDR_W  byte address of the current beat
mem_wdata  out  8  byte to write
mem_rdata  in  8  read byte, valid the cycle after mem_en & ~mem_we
err  out  1  bounds error, valid with a done pulse (see optional feature)

Behaviour:
- States: IDLE, BEAT, WAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present (accept cycle c0):
  - Latch owner, we, size, unsigned, addr, wdata.
  - Beat count N = 1, 2 or 4 from size.
  - Set beat index k=0 and go to BEAT.
- BEAT (cycles c1..cN):
  - mem_en=1, mem_we=latched we.
  - mem_addr = addr+k, mem_wdata = wdata[8k+7:8k].
  - k increments each cycle; after k=N-1 go to WAIT.
- Read capture: the byte issued at beat k is captured into buffer byte k in the following cycle. This capture is pipelined with the next beat.
- WAIT (cycle cN+1): capture the last byte; mem_en=0.
- RESP (cycle cN+2):
  - Owner's done=1 for exactly one cycle.
  - For a load, owner's rdata is registered: byte loads extend bit 7 (sign) or zero-extend when unsigned; half loads extend bit 15 the same way; word loads pass through.
  - For a store, rdata=0.
  - Next state is IDLE.
- Latency: done arrives N+2 cycles after the accept cycle, identical for loads and stores (byte 3, half 4, word 6).
- Arbitration in IDLE:
  - One requester: grant it.
  - Both requesting: round-robin on a last_grant register, which is updated on each accept. Reset value of last_grant favours the core.
- Request deasserted mid-transaction: ignored; the transaction completes and done still pulses.
- Back-to-back: a request still high in the IDLE cycle after done is a new transaction. Requesters drop req in the cycle after done unless they issue another access.
- core_stall = core_req & ~core_done. Combinational; covers both waiting for arbitration and the access in flight.
- Non-owner rdata/done hold 0; rdata is cleared when its next transaction is accepted.
- Reset (rst=0 at a clock edge), including mid-transaction:
  - State IDLE, k=0, last_grant=core.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Both rdata=0, both done=0, err=0.
  - No done pulse for the aborted access; bytes already written stay written.

Optional Feature:
- Macro DMEM_BOUNDS_CHECK_EN defined:
  - At accept, check whether any byte address addr..addr+N-1 is >= MEM_BYTES. If so, the transaction keeps the same latency with mem_en held 0.
  - In RESP, rdata=0 and err=1 with done.
  - In-range transactions give err=0.
- Macro not defined: mem_addr = (addr+k) mod MEM_BYTES, so accesses wrap around; err is tied to 0.

Test Plan:
1. Core word store 0xDEADBEEF at 0x10 -> beats c1..c4 write EF@0x10, BE@0x11, AD@0x12, DE@0x13; core_done at c6; core_stall high c0..c5, low at c6.
2. Following loads:
   - lb 0x10 -> core_rdata 0xFFFFFFEF at c3.
   - lbu 0x10 -> 0x000000EF.
   - lh 0x12 -> 0xFFFFDEAD at c4.
   - lw 0x10 -> 0xDEADBEEF at c6.
3. core_req and dbg_req rise together after reset -> core granted first; dbg accepted in the IDLE cycle after core_done. On the next simultaneous request, dbg wins (round-robin).
4. rst=0 at c3 of a word store to 0x20 -> only 0x20 and 0x21 written; no done; outputs at reset values. A subsequent byte load completes in 3 cycles.
5. Word store 0x11223344 at 0x7E, MEM_BYTES=128:
   - Without macro: writes 44@0x7E, 33@0x7F, 22@0x00, 11@0x01.
   - With DMEM_BOUNDS_CHECK_EN: no mem_en, and err=1 with core_done at c6.
6. dbg_req dropped at c2 of a half load -> transaction still completes; dbg_done pulses at c4 with the correct data.
